hm2_irq_timer: RTL and testbench

HM2_IRQ_TIMER -- requirements
Module: hm2_irq_timer

---
 rtl/hm2_irq_timer.sv | 66 ++++++
 tb/tb_hm2_irq_timer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/hm2_irq_timer.sv
// hm2_irq_timer: prescaled periodic interrupt timer; clk/reset, bus_* register port (combinational read), irq_n active-low registered interrupt
module hm2_irq_timer #(
  parameter int ADDRESS_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR = 14'h0100
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH-1:0] bus_address,
  input  logic [DATA_WIDTH-1:0]    bus_datain,
  input  logic                     bus_write,
  input  logic                     bus_read,
  input  logic                     bus_chip_sel,
  output logic [DATA_WIDTH-1:0]    bus_dataout,
  output logic                     irq_n
);
  logic [DATA_WIDTH-1:0] rate, count, events;
  logic [15:0] prescale, pre;
  logic [2:0] off;
  logic en, irq_en, pending, overrun;
  logic hit, wr, tick, low, evt, start, clr_p, clr_o, unused_read;
  assign unused_read = bus_read;
  assign hit = bus_chip_sel & (bus_address[ADDRESS_WIDTH-1:3] == BASE_ADDR[ADDRESS_WIDTH-1:3]);
  assign off = bus_address[2:0];
  assign wr = bus_write & hit;
  assign tick = en & (pre == prescale);
  assign low = count[DATA_WIDTH-1:1] == '0;
  assign evt = tick & low & (rate != '0);
  assign start = wr & (off == 3'd2) & bus_datain[0] & ~en;
  assign clr_p = wr & (off == 3'd3) & bus_datain[0];
  assign clr_o = wr & (off == 3'd3) & bus_datain[1];
  always_comb
    bus_dataout = !hit        ? '0 :
                  off == 3'd0 ? rate :
                  off == 3'd1 ? DATA_WIDTH'(prescale) :
                  off == 3'd2 ? DATA_WIDTH'({irq_en, en}) :
                  off == 3'd3 ? DATA_WIDTH'({overrun, pending}) :
                  off == 3'd4 ? count :
                  off == 3'd5 ? events : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      rate     <= '0;
      prescale <= '0;
      en       <= 1'b0;
      irq_en   <= 1'b0;
      pending  <= 1'b0;
      overrun  <= 1'b0;
      count    <= '0;
      events   <= '0;
      pre      <= '0;
      irq_n    <= 1'b1;
    end else begin
      irq_n <= ~(pending & irq_en);
      if (wr && off == 3'd0) rate <= bus_datain;
      if (wr && off == 3'd1) prescale <= bus_datain[15:0];
      if (wr && off == 3'd2) {irq_en, en} <= bus_datain[1:0];
      // a coinciding event beats the write-1-to-clear
      pending <= evt | (pending & ~clr_p);
      overrun <= (evt & pending) | (overrun & ~clr_o);
      if (evt) events <= events + 1'b1;
      // with RATE=0 the reload value is 0, so COUNT parks at 0 without an event
      count <= start ? rate : tick ? (low ? rate : count - 1'b1) : count;
      pre <= (start || tick || (wr && off == 3'd1)) ? 16'd0 : en ? pre + 16'd1 : pre;
    end
  end
endmodule

// File: tb/tb_hm2_irq_timer.sv
// tb_hm2_irq_timer: directed and randomized checks of hm2_irq_timer against a rule-based reference model
module tb_hm2_irq_timer;
  localparam logic [13:0] BASE = 14'h0100;
  logic clk, reset, bus_write, bus_read, bus_chip_sel, irq_n;
  logic [13:0] bus_address;
  logic [31:0] bus_datain, bus_dataout;
  int total = 0, passed = 0, failed = 0;
  logic [31:0] m_rate, m_cnt, m_ev, v;
  logic [15:0] m_pres, m_pre;
  logic m_en, m_ie, m_pend, m_ovr, m_irqn;

  hm2_irq_timer dut (
    .clk(clk), .reset(reset), .bus_address(bus_address), .bus_datain(bus_datain),
    .bus_write(bus_write), .bus_read(bus_read), .bus_chip_sel(bus_chip_sel),
    .bus_dataout(bus_dataout), .irq_n(irq_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  // reference: next state from the register rules, using pre-edge values
  task automatic model(input logic rs, input logic cs, input logic [13:0] a, input logic w, input logic [31:0] d);
    logic tick, lo, evt, start;
    logic [2:0] wo;
    if (rs) begin
      m_rate = 0; m_pres = 0; m_en = 0; m_ie = 0; m_pend = 0; m_ovr = 0;
      m_cnt = 0; m_ev = 0; m_pre = 0; m_irqn = 1;
    end else begin
      wo = (w && cs && a[13:3] == BASE[13:3]) ? a[2:0] : 3'd7;
      tick = m_en && m_pre == m_pres;
      lo = m_cnt <= 1;
      evt = tick && lo && m_rate != 0;
      start = wo == 3'd2 && d[0] && !m_en;
      m_irqn = !(m_pend && m_ie);
      m_ovr = (evt && m_pend) || (m_ovr && !(wo == 3'd3 && d[1]));
      m_pend = evt || (m_pend && !(wo == 3'd3 && d[0]));
      if (evt) m_ev = m_ev + 1;
      if (start) m_cnt = m_rate;
      else if (tick) m_cnt = lo ? m_rate : m_cnt - 1;
      if (start || tick || wo == 3'd1) m_pre = 0;
      else if (m_en) m_pre = m_pre + 1;
      if (wo == 3'd0) m_rate = d;
      if (wo == 3'd1) m_pres = d[15:0];
      if (wo == 3'd2) {m_ie, m_en} = d[1:0];
    end
  endtask

  task automatic step(input logic rs, input logic cs, input logic [13:0] a, input logic w, input logic [31:0] d);
    reset = rs; bus_chip_sel = cs; bus_address = a; bus_write = w; bus_datain = d;
    model(rs, cs, a, w, d);
    @(posedge clk);
    #1;
    reset = 1'b0; bus_write = 1'b0; bus_chip_sel = 1'b0;
  endtask

  task automatic wr(input logic [2:0] o, input logic [31:0] d);
    step(1'b0, 1'b1, BASE + 14'(o), 1'b1, d);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 14'd0, 1'b0, 32'd0);
  endtask

  task automatic rd(input logic [13:0] a, input logic cs, output logic [31:0] val);
    bus_address = a; bus_chip_sel = cs;
    #1;
    val = bus_dataout;
    bus_chip_sel = 1'b0;
  endtask

  task automatic chk_all(input string t);
    logic [31:0] exp [6];
    logic [31:0] got;
    exp = '{m_rate, {16'd0, m_pres}, {30'd0, m_ie, m_en}, {30'd0, m_ovr, m_pend}, m_cnt, m_ev};
    for (int i = 0; i < 6; i++) begin
      rd(BASE + 14'(i), 1'b1, got);
      chk($sformatf("%s_off%0d", t, i), got, exp[i]);
    end
    chk({t, "_irq_n"}, {31'd0, irq_n}, {31'd0, m_irqn});
  endtask

  initial begin
    bus_read = 1'b0; bus_write = 1'b0; bus_chip_sel = 1'b0; reset = 1'b0;
    bus_address = '0; bus_datain = '0;
    // reset state
    step(1'b1, 1'b0, 14'd0, 1'b0, 32'd0);
    chk_all("reset");
    for (int i = 0; i < 6; i++) begin rd(BASE + 14'(i), 1'b1, v); chk("reset_zero", v, 32'd0); end
    chk("reset_irq_n", {31'd0, irq_n}, 32'd1);
    // RATE=3, PRESCALE=0, CONTROL=3: event every 3 cycles
    wr(3'd0, 32'd3);
    wr(3'd2, 32'd3);
    repeat (2) begin idle(); chk_all("r31"); end
    idle();
    rd(BASE + 14'd3, 1'b1, v); chk("r31_pending", v, 32'd1);
    rd(BASE + 14'd5, 1'b1, v); chk("r31_events", v, 32'd1);
    chk("r31_irq_late", {31'd0, irq_n}, 32'd1);
    idle();
    chk("r31_irq_low", {31'd0, irq_n}, 32'd0);
    idle(); idle();
    rd(BASE + 14'd3, 1'b1, v); chk("overrun", v, 32'd3);
    rd(BASE + 14'd5, 1'b1, v); chk("r31_events2", v, 32'd2);
    wr(3'd3, 32'd3);
    rd(BASE + 14'd3, 1'b1, v); chk("w1c", v, 32'd0);
    idle();
    chk("w1c_irq_high", {31'd0, irq_n}, 32'd1);
    chk_all("w1c");
    idle(); idle(); idle();
    wr(3'd3, 32'd1);
    rd(BASE + 14'd3, 1'b1, v); chk("set_wins", v, 32'd3);
    idle();
    chk("set_wins_irq", {31'd0, irq_n}, 32'd0);
    chk_all("set_wins");
    // RATE=2, PRESCALE=4: event every 10 cycles
    step(1'b1, 1'b0, 14'd0, 1'b0, 32'd0);
    wr(3'd0, 32'd2);
    wr(3'd1, 32'd4);
    wr(3'd2, 32'd1);
    for (int i = 1; i <= 20; i++) begin
      idle();
      rd(BASE + 14'd4, 1'b1, v); chk($sformatf("r32_count%0d", i), v, (i % 10) < 5 ? 32'd2 : 32'd1);
      rd(BASE + 14'd5, 1'b1, v); chk($sformatf("r32_events%0d", i), v, 32'(i / 10));
    end
    chk_all("r32");
    // decode misses: read zero, writes ignored
    rd(BASE + 14'd6, 1'b1, v); chk("rd_reserved", v, 32'd0);
    rd(BASE + 14'd8, 1'b1, v); chk("rd_other_block", v, 32'd0);
    rd(BASE, 1'b0, v); chk("rd_no_cs", v, 32'd0);
    step(1'b0, 1'b1, BASE + 14'd8, 1'b1, 32'd9);
    step(1'b0, 1'b0, BASE, 1'b1, 32'd9);
    wr(3'd6, 32'hffff_ffff);
    wr(3'd4, 32'd77);
    wr(3'd5, 32'd77);
    rd(BASE, 1'b1, v); chk("rate_kept", v, 32'd2);
    chk_all("r35");
    // reset mid-count with an interrupt pending
    step(1'b1, 1'b0, 14'd0, 1'b0, 32'd0);
    wr(3'd0, 32'd7);
    wr(3'd2, 32'd3);
    repeat (9) idle();
    rd(BASE + 14'd4, 1'b1, v); chk("r36_count5", v, 32'd5);
    chk("r36_irq_low", {31'd0, irq_n}, 32'd0);
    step(1'b1, 1'b0, 14'd0, 1'b0, 32'd0);
    chk("r36_irq_high", {31'd0, irq_n}, 32'd1);
    chk_all("r36");
    repeat (20) idle();
    rd(BASE + 14'd5, 1'b1, v); chk("r36_no_event", v, 32'd0);
    rd(BASE + 14'd3, 1'b1, v); chk("r36_status", v, 32'd0);
    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      int r;
      logic [2:0] o;
      logic [31:0] d;
      r = $urandom_range(0, 99);
      o = 3'($urandom_range(0, 7));
      d = o == 3'd0 ? 32'($urandom_range(0, 5)) : o == 3'd1 ? 32'($urandom_range(0, 3)) : $urandom;
      if (r < 1) step(1'b1, 1'b0, 14'd0, 1'b0, 32'd0);
      else if (r < 70) idle();
      else if (r < 90) wr(o, d);
      else step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)) ^ 1'b1, BASE + 14'd8 + 14'(o), 1'b1, d);
      chk_all("rand");
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
